// File: rtl/counter_sequencer.sv
// Sequences a loadable up-counter through programmed count windows.
// Accepts {start,end,mode}, loads the counter, enables it until Count==end, pulses Done.
module counter_sequencer #(
  parameter int WIDTH = 6,
  parameter int PCW   = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [WIDTH-1:0] CmdStart,
  input  logic [WIDTH-1:0] CmdEnd,
  input  logic             CmdMode,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Count,
  output logic             CntEnable,
  output logic             CntLoad,
  output logic [WIDTH-1:0] CntData,
  output logic             Busy,
  output logic             Done,
  output logic             Aborted,
  output logic [PCW-1:0]   PeriodCount
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] start_q, end_q;
  logic             mode_q;
  logic             accept, at_end, abort_act;

  assign at_end    = (Count == end_q);
  assign abort_act = Abort && (state != IDLE);
  assign accept    = (state == IDLE) && CmdValid && CmdReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      mode_q      <= 1'b0;
      PeriodCount <= '0;
      Aborted     <= 1'b0;
    end else begin
      state   <= state_nxt;
      Aborted <= abort_act;
      if (accept) begin
        start_q     <= CmdStart;
        end_q       <= CmdEnd;
        mode_q      <= CmdMode;
        PeriodCount <= '0;
      end else if (state == DONE && !Abort && PeriodCount != '1) begin
        PeriodCount <= PeriodCount + PCW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (at_end) state_nxt = DONE;
      DONE: state_nxt = mode_q ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort wins over Done and reload
    if (abort_act) state_nxt = IDLE;
  end

  always_comb begin
    CntEnable = 1'b0;
    CntLoad   = 1'b0;
    Done      = 1'b0;
    case (state)
      LOAD: begin
        CntEnable = !Abort;
        CntLoad   = !Abort;
      end
      RUN:  CntEnable = !Abort && !at_end;
      DONE: Done      = !Abort;
      default: ;
    endcase
  end

  assign CntData  = start_q;
  assign Busy     = (state != IDLE);
  assign CmdReady = (state == IDLE) && !Abort;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural counter closes the loop, and expected
// outputs come from window arithmetic (period = 1 LOAD + N RUN + 1 DONE).
module tb_counter_sequencer;
  logic       Clock = 1'b0;
  logic       Reset, CmdValid, CmdReady, CmdMode, Abort;
  logic [5:0] CmdStart, CmdEnd, Count, CntData;
  logic       CntEnable, CntLoad, Busy, Done, Aborted;
  logic [7:0] PeriodCount;
  logic [5:0] cnt = '0;
  int         checks = 0;
  int         fails  = 0;

  counter_sequencer #(.WIDTH(6), .PCW(8)) dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdStart(CmdStart), .CmdEnd(CmdEnd), .CmdMode(CmdMode), .Abort(Abort),
    .Count(Count), .CntEnable(CntEnable), .CntLoad(CntLoad), .CntData(CntData),
    .Busy(Busy), .Done(Done), .Aborted(Aborted), .PeriodCount(PeriodCount)
  );

  always #5 Clock = ~Clock;

  // The external Enable/Load/Data counter being sequenced.
  always @(posedge Clock) begin
    if (CntLoad) cnt <= CntData;
    else if (CntEnable) cnt <= cnt + 6'd1;
  end
  assign Count = cnt;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int k);
    return (k > 255) ? 255 : k;
  endfunction

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic issue(input logic [5:0] s, input logic [5:0] e, input logic m);
    int k = 0;
    CmdValid = 1'b1; CmdStart = s; CmdEnd = e; CmdMode = m;
    #1;
    while (!CmdReady && k < 20) begin step(); k++; end
    chk("accept_ready", int'(CmdReady), 1);
    step();
    CmdValid = 1'b0;
  endtask

  // Walks the expected timeline from the LOAD cycle onward; abort injected at (ab_per, ab_p).
  task automatic follow(input logic [5:0] s, input logic [5:0] e, input logic m,
                        input int nper, input int ab_per, input int ab_p);
    int n;
    n = ((int'(e) - int'(s)) & 63) + 1;
    for (int per = 0; per < nper; per++) begin
      for (int p = 0; p <= n + 1; p++) begin
        if (per == ab_per && p == ab_p) begin
          Abort = 1'b1; #1;
          chk("abort_en",   int'(CntEnable), 0);
          chk("abort_load", int'(CntLoad), 0);
          chk("abort_done", int'(Done), 0);
          step();
          Abort = 1'b0; #1;
          chk("aborted_pulse", int'(Aborted), 1);
          chk("abort_idle",    int'(Busy), 0);
          chk("abort_pc",      int'(PeriodCount), sat(per));
          step();
          chk("aborted_clear", int'(Aborted), 0);
          return;
        end
        chk("busy", int'(Busy), 1);
        chk("ready_busy", int'(CmdReady), 0);
        if (p == 0) begin
          chk("load",      int'(CntLoad), 1);
          chk("load_en",   int'(CntEnable), 1);
          chk("load_data", int'(CntData), int'(s));
          chk("load_pc",   int'(PeriodCount), sat(per));
        end else if (p <= n) begin
          chk("run_count", int'(Count), (int'(s) + p - 1) & 63);
          chk("run_en",    int'(CntEnable), (p < n) ? 1 : 0);
          chk("run_load",  int'(CntLoad), 0);
          chk("run_done",  int'(Done), 0);
        end else begin
          chk("done",      int'(Done), 1);
          chk("done_en",   int'(CntEnable), 0);
        end
        step();
      end
    end
    if (!m) begin
      chk("end_idle",  int'(Busy), 0);
      chk("end_ready", int'(CmdReady), 1);
      chk("end_pc",    int'(PeriodCount), sat(nper));
      chk("end_done",  int'(Done), 0);
    end
  endtask

  initial begin
    logic [5:0] rs, re;
    logic       rm;
    int         rn, ap;
    Reset = 1'b1; CmdValid = 1'b0; CmdStart = '0; CmdEnd = '0; CmdMode = 1'b0; Abort = 1'b0;
    step(); step();
    chk("rst_ready", int'(CmdReady), 1);
    chk("rst_en",    int'(CntEnable), 0);
    chk("rst_load",  int'(CntLoad), 0);
    chk("rst_data",  int'(CntData), 0);
    chk("rst_busy",  int'(Busy), 0);
    chk("rst_done",  int'(Done), 0);
    chk("rst_abt",   int'(Aborted), 0);
    chk("rst_pc",    int'(PeriodCount), 0);
    Reset = 1'b0;

    // Directed windows: basic, wrap, single-cycle.
    issue(6'd5, 6'd9, 1'b0);   follow(6'd5, 6'd9, 1'b0, 1, -1, -1);
    issue(6'd62, 6'd1, 1'b0);  follow(6'd62, 6'd1, 1'b0, 1, -1, -1);
    issue(6'd20, 6'd20, 1'b0); follow(6'd20, 6'd20, 1'b0, 1, -1, -1);

    // Auto-reload, stopped by abort in LOAD of the 4th period.
    issue(6'd0, 6'd3, 1'b1);   follow(6'd0, 6'd3, 1'b1, 4, 3, 0);

    // Abort in RUN when Count==7.
    issue(6'd4, 6'd12, 1'b0);  follow(6'd4, 6'd12, 1'b0, 1, 0, 4);

    // PeriodCount saturation with 3-cycle periods.
    issue(6'd7, 6'd7, 1'b1);   follow(6'd7, 6'd7, 1'b1, 258, 257, 0);

    // Reset mid-RUN after one completed auto period.
    issue(6'd0, 6'd3, 1'b1);   follow(6'd0, 6'd3, 1'b1, 1, -1, -1);
    step(); step();
    chk("pre_rst_pc", int'(PeriodCount), 1);
    Reset = 1'b1; step(); Reset = 1'b0; #1;
    chk("mid_rst_busy",  int'(Busy), 0);
    chk("mid_rst_ready", int'(CmdReady), 1);
    chk("mid_rst_en",    int'(CntEnable), 0);
    chk("mid_rst_data",  int'(CntData), 0);
    chk("mid_rst_pc",    int'(PeriodCount), 0);
    chk("mid_rst_done",  int'(Done), 0);
    step();
    chk("mid_rst_nodone", int'(Done), 0);

    // Abort in IDLE blocks acceptance of a pending command.
    Abort = 1'b1; CmdValid = 1'b1; CmdStart = 6'd10; CmdEnd = 6'd12; CmdMode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_abort_ready", int'(CmdReady), 0);
      chk("idle_abort_busy",  int'(Busy), 0);
      step();
    end
    chk("idle_abort_noabt", int'(Aborted), 0);
    Abort = 1'b0;
    issue(6'd10, 6'd12, 1'b0); follow(6'd10, 6'd12, 1'b0, 1, -1, -1);

    // Randomized windows, some aborted.
    for (int t = 0; t < 20; t++) begin
      rs = 6'($urandom_range(0, 63));
      re = 6'($urandom_range(0, 63));
      rm = 1'($urandom_range(0, 1));
      rn = ((int'(re) - int'(rs)) & 63) + 1;
      ap = $urandom_range(0, rn + 1);
      issue(rs, re, rm);
      if (rm) follow(rs, re, rm, 2, 1, ap);
      else if ($urandom_range(0, 2) == 0) follow(rs, re, rm, 1, 0, ap);
      else follow(rs, re, rm, 1, -1, -1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
